// File: rtl/alu64_pkg.sv
// alu64_pkg: shared constants for the 64-bit execute-stage slice.
//   Opcodes, ALU operation codes, branch codes, and the widths and bit
//   positions of the EX/MEM/WB control fields.
package alu64_pkg;

   localparam int unsigned XLEN = 64;
   localparam int unsigned ILEN = 32;

   typedef enum logic [6:0] {
      OP_RTYPE  = 7'b0110011,
      OP_IALU   = 7'b0010011,
      OP_LOAD   = 7'b0000011,
      OP_STORE  = 7'b0100011,
      OP_BRANCH = 7'b1100011,
      OP_JAL    = 7'b1101111,
      OP_FIFO   = 7'b0001011
   } opcode_e;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b1000,
      ALU_SLL  = 4'b0001,
      ALU_SLT  = 4'b0010,
      ALU_SLTU = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SRL  = 4'b0101,
      ALU_SRA  = 4'b1101,
      ALU_OR   = 4'b0110,
      ALU_AND  = 4'b0111
   } aluop_e;

   typedef enum logic [1:0] {
      BR_BEQ  = 2'b00,
      BR_BNE  = 2'b01,
      BR_BLT  = 2'b10,
      BR_NONE = 2'b11
   } branch_e;

   // EX_CTRL = {ALUSrc, ALUop[3:0], RegDst}
   localparam int unsigned EX_CTRL_W    = 6;
   localparam int unsigned EX_ALUSRC    = 5;
   localparam int unsigned EX_ALUOP_LSB = 1;
   localparam int unsigned EX_REGDST    = 0;

   // MEM_CTRL = {Branch[1:0], Jump, WMemEn}
   localparam int unsigned MEM_CTRL_W     = 4;
   localparam int unsigned MEM_BRANCH_LSB = 2;
   localparam int unsigned MEM_JUMP       = 1;
   localparam int unsigned MEM_WMEMEN     = 0;

   // WB_CTRL = {FifoInfo, MemtoReg, WRegEn}
   localparam int unsigned WB_CTRL_W   = 3;
   localparam int unsigned WB_FIFO     = 2;
   localparam int unsigned WB_MEMTOREG = 1;
   localparam int unsigned WB_WREGEN   = 0;

   localparam int unsigned IMM_W = 12;

   localparam logic [MEM_CTRL_W-1:0] MEM_CTRL_RESET = {BR_NONE, 1'b0, 1'b0};

endpackage

// File: rtl/alu64_decode.sv
// alu64_decode: combinational instruction decoder.
//   instr    in  32  instruction in EX
//   ex_ctrl  out  6  {ALUSrc, ALUop[3:0], RegDst}
//   mem_ctrl out  4  {Branch[1:0], Jump, WMemEn}
//   wb_ctrl  out  3  {FifoInfo, MemtoReg, WRegEn}
//   imm      out 12  raw immediate (sign extension done by the consumer)
// Unlisted opcodes decode as a bubble (all enables low, Branch=NONE).
module alu64_decode
   import alu64_pkg::*;
(
   input  logic [ILEN-1:0]       instr,
   output logic [EX_CTRL_W-1:0]  ex_ctrl,
   output logic [MEM_CTRL_W-1:0] mem_ctrl,
   output logic [WB_CTRL_W-1:0]  wb_ctrl,
   output logic [IMM_W-1:0]      imm
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       b30;

   logic       alu_src;
   logic [3:0] alu_op;
   logic       reg_dst;
   logic [1:0] branch;
   logic       jump;
   logic       wmem_en;
   logic       fifo_info;
   logic       mem_to_reg;
   logic       wreg_en;

   // rs1 is consumed upstream as r1data; the field itself is not needed here.
   logic [4:0] unused_rs1;

   assign opcode     = instr[6:0];
   assign funct3     = instr[14:12];
   assign b30        = instr[30];
   assign unused_rs1 = instr[19:15];

   always_comb begin
      alu_src    = 1'b0;
      alu_op     = ALU_ADD;
      reg_dst    = 1'b0;
      branch     = BR_NONE;
      jump       = 1'b0;
      wmem_en    = 1'b0;
      fifo_info  = 1'b0;
      mem_to_reg = 1'b0;
      wreg_en    = 1'b0;
      imm        = '0;
      case (opcode)
         OP_RTYPE: begin
            alu_op  = {b30, funct3};
            reg_dst = 1'b1;
            wreg_en = 1'b1;
         end
         OP_IALU: begin
            alu_src = 1'b1;
            imm     = instr[31:20];
            // b30 only selects SRA vs SRL; for other I-ops it is immediate data.
            alu_op  = {(funct3 == 3'b101) ? b30 : 1'b0, funct3};
            reg_dst = 1'b1;
            wreg_en = 1'b1;
         end
         OP_LOAD: begin
            alu_src    = 1'b1;
            imm        = instr[31:20];
            mem_to_reg = 1'b1;
            wreg_en    = 1'b1;
         end
         OP_STORE: begin
            alu_src = 1'b1;
            imm     = {instr[31:25], instr[11:7]};
            wmem_en = 1'b1;
         end
         OP_BRANCH: begin
            alu_op = ALU_SUB;
            imm    = {instr[31:25], instr[11:7]};
            case (funct3)
               3'b000:  branch = BR_BEQ;
               3'b001:  branch = BR_BNE;
               3'b100:  branch = BR_BLT;
               default: branch = BR_NONE;
            endcase
         end
         OP_JAL: begin
            jump = 1'b1;
            imm  = instr[31:20];
         end
         OP_FIFO: begin
            fifo_info  = 1'b1;
            wreg_en    = 1'b1;
            mem_to_reg = funct3[0];
         end
         default: ;
      endcase
   end

   assign ex_ctrl  = {alu_src, alu_op, reg_dst};
   assign mem_ctrl = {branch, jump, wmem_en};
   assign wb_ctrl  = {fifo_info, mem_to_reg, wreg_en};

endmodule

// File: rtl/alu_64bit.sv
// alu_64bit: execute stage of the 64-bit pipeline plus the EX/MEM register.
//   clk, reset        rising-edge clock, synchronous active-high reset
//   instr        in   32  instruction in EX
//   r1data       in   64  rs1 operand (ALU A)
//   r2data       in   64  rs2 operand (ALU B when ALUSrc=0, store data)
//   mem_wreg     out   5  destination register
//   mem_alu_out  out  64  ALU result
//   mem_r2out    out  64  registered r2data
//   mem_mem_ctrl out   4  {Branch[1:0], Jump, WMemEn}
//   mem_wb_ctrl  out   3  {FifoInfo, MemtoReg, WRegEn}
//   mem_imm      out   9  imm[8:0], absolute branch/jump target
//   mem_carry    out   1  registered carry flag
//   mem_overflow out   1  registered signed-overflow flag
// Build option: define ALU64_SHIFT_EN to implement SLL/SRL/SRA; without it
// those ops return 0.
module alu_64bit
   import alu64_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ILEN-1:0]       instr,
   input  logic [XLEN-1:0]       r1data,
   input  logic [XLEN-1:0]       r2data,
   output logic [4:0]            mem_wreg,
   output logic [XLEN-1:0]       mem_alu_out,
   output logic [XLEN-1:0]       mem_r2out,
   output logic [MEM_CTRL_W-1:0] mem_mem_ctrl,
   output logic [WB_CTRL_W-1:0]  mem_wb_ctrl,
   output logic [8:0]            mem_imm,
   output logic                  mem_carry,
   output logic                  mem_overflow
);

   logic [EX_CTRL_W-1:0]  ex_ctrl;
   logic [MEM_CTRL_W-1:0] mem_ctrl;
   logic [WB_CTRL_W-1:0]  wb_ctrl;
   logic [IMM_W-1:0]      imm;

   alu64_decode u_decode (
      .instr    (instr),
      .ex_ctrl  (ex_ctrl),
      .mem_ctrl (mem_ctrl),
      .wb_ctrl  (wb_ctrl),
      .imm      (imm)
   );

   logic            alu_src;
   logic [3:0]      alu_op;
   logic            reg_dst;
   logic [XLEN-1:0] imm_ext;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [4:0]      wreg;
   logic [XLEN:0]   sum65;
   logic [XLEN:0]   diff65;
   logic [XLEN-1:0] alu_y;
   logic            carry;
   logic            overflow;

   assign alu_src = ex_ctrl[EX_ALUSRC];
   assign alu_op  = ex_ctrl[EX_ALUOP_LSB +: 4];
   assign reg_dst = ex_ctrl[EX_REGDST];

   assign imm_ext = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
   assign a       = r1data;
   assign b       = alu_src ? imm_ext : r2data;
   assign wreg    = reg_dst ? instr[11:7] : instr[24:20];

   // 65-bit forms expose the carry-out as the top bit.
   assign sum65  = {1'b0, a} + {1'b0, b};
   assign diff65 = {1'b0, a} + {1'b0, ~b} + {{XLEN{1'b0}}, 1'b1};

`ifdef ALU64_SHIFT_EN
   logic [5:0] shamt;
   assign shamt = b[5:0];
`endif

   always_comb begin
      alu_y    = '0;
      carry    = 1'b0;
      overflow = 1'b0;
      case (alu_op)
         ALU_ADD: begin
            alu_y    = sum65[XLEN-1:0];
            carry    = sum65[XLEN];
            overflow = (a[XLEN-1] == b[XLEN-1]) && (sum65[XLEN-1] != a[XLEN-1]);
         end
         ALU_SUB: begin
            alu_y    = diff65[XLEN-1:0];
            carry    = diff65[XLEN];
            overflow = (a[XLEN-1] != b[XLEN-1]) && (diff65[XLEN-1] != a[XLEN-1]);
         end
         ALU_SLT:  alu_y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         ALU_SLTU: alu_y = {{(XLEN-1){1'b0}}, (a < b)};
         ALU_XOR:  alu_y = a ^ b;
         ALU_OR:   alu_y = a | b;
         ALU_AND:  alu_y = a & b;
`ifdef ALU64_SHIFT_EN
         ALU_SLL:  alu_y = a << shamt;
         ALU_SRL:  alu_y = a >> shamt;
         ALU_SRA:  alu_y = $signed(a) >>> shamt;
`endif
         default:  alu_y = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_wreg     <= '0;
         mem_alu_out  <= '0;
         mem_r2out    <= '0;
         mem_mem_ctrl <= MEM_CTRL_RESET;
         mem_wb_ctrl  <= '0;
         mem_imm      <= '0;
         mem_carry    <= 1'b0;
         mem_overflow <= 1'b0;
      end else begin
         mem_wreg     <= wreg;
         mem_alu_out  <= alu_y;
         mem_r2out    <= r2data;
         mem_mem_ctrl <= mem_ctrl;
         mem_wb_ctrl  <= wb_ctrl;
         mem_imm      <= imm[8:0];
         mem_carry    <= carry;
         mem_overflow <= overflow;
      end
   end

endmodule

// File: tb/tb_alu_64bit.sv
// tb_alu_64bit: scoreboard bench for alu_64bit. Each step drives one
// instruction, queues the hand-derived EX/MEM contents, and compares them
// one cycle later.
module tb_alu_64bit;

   typedef struct {
      logic [4:0]  wreg;
      logic [63:0] alu;
      logic [63:0] r2;
      logic [3:0]  memc;
      logic [2:0]  wbc;
      logic [8:0]  imm;
      logic        c;
      logic        v;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic [63:0] r1data;
   logic [63:0] r2data;
   logic [4:0]  mem_wreg;
   logic [63:0] mem_alu_out;
   logic [63:0] mem_r2out;
   logic [3:0]  mem_mem_ctrl;
   logic [2:0]  mem_wb_ctrl;
   logic [8:0]  mem_imm;
   logic        mem_carry;
   logic        mem_overflow;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;
   exp_t        sb[$];

   alu_64bit dut (
      .clk          (clk),
      .reset        (reset),
      .instr        (instr),
      .r1data       (r1data),
      .r2data       (r2data),
      .mem_wreg     (mem_wreg),
      .mem_alu_out  (mem_alu_out),
      .mem_r2out    (mem_r2out),
      .mem_mem_ctrl (mem_mem_ctrl),
      .mem_wb_ctrl  (mem_wb_ctrl),
      .mem_imm      (mem_imm),
      .mem_carry    (mem_carry),
      .mem_overflow (mem_overflow)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic [4:0] wreg, input logic [63:0] alu,
                               input logic [63:0] r2, input logic [3:0] memc,
                               input logic [2:0] wbc, input logic [8:0] imm,
                               input logic c, input logic v);
      exp_t e;
      e.wreg = wreg; e.alu = alu; e.r2 = r2; e.memc = memc;
      e.wbc = wbc; e.imm = imm; e.c = c; e.v = v;
      return e;
   endfunction

   function automatic logic [31:0] enc_r(input logic b30, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {1'b0, b30, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [6:0] op);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
   endfunction

   task automatic step(input string tag, input logic rst, input logic [31:0] ins,
                       input logic [63:0] a, input logic [63:0] b, input exp_t e);
      exp_t got;
      reset  = rst;
      instr  = ins;
      r1data = a;
      r2data = b;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL %s.sb: got empty scoreboard expected an entry", tag);
      end else begin
         got = sb.pop_front();
         check_eq({tag, ".wreg"}, {59'b0, mem_wreg},     {59'b0, got.wreg});
         check_eq({tag, ".alu"},  mem_alu_out,            got.alu);
         check_eq({tag, ".r2"},   mem_r2out,              got.r2);
         check_eq({tag, ".memc"}, {60'b0, mem_mem_ctrl},  {60'b0, got.memc});
         check_eq({tag, ".wbc"},  {61'b0, mem_wb_ctrl},   {61'b0, got.wbc});
         check_eq({tag, ".imm"},  {55'b0, mem_imm},       {55'b0, got.imm});
         check_eq({tag, ".c"},    {63'b0, mem_carry},     {63'b0, got.c});
         check_eq({tag, ".v"},    {63'b0, mem_overflow},  {63'b0, got.v});
      end
   endtask

   initial begin
      logic [63:0] sra_exp, srl_exp, sll_exp;
      logic [31:0] sw_instr;
`ifdef ALU64_SHIFT_EN
      sra_exp = 64'hF800_0000_0000_0000;
      srl_exp = 64'h0800_0000_0000_0000;
      sll_exp = 64'd8;
`else
      sra_exp = 64'd0;
      srl_exp = 64'd0;
      sll_exp = 64'd0;
`endif
      reset = 1'b1; instr = '0; r1data = '0; r2data = '0;
      @(posedge clk); #1;

      step("rst", 1'b1, 32'h0000_0033, 64'h1234, 64'h5678,
           mk(5'd0, 64'd0, 64'd0, 4'b1100, 3'b000, 9'd0, 1'b0, 1'b0));
      step("add_ovf", 1'b0, enc_r(1'b0, 5'd2, 5'd1, 3'b000, 5'd5),
           64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
           mk(5'd5, 64'h8000_0000_0000_0000, 64'd1, 4'b1100, 3'b001, 9'd0, 1'b0, 1'b1));
      step("sub_neg", 1'b0, enc_r(1'b1, 5'd2, 5'd1, 3'b000, 5'd3), 64'd0, 64'd1,
           mk(5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b1100, 3'b001, 9'd0, 1'b0, 1'b0));
      step("sub_eq", 1'b0, enc_r(1'b1, 5'd2, 5'd1, 3'b000, 5'd4), 64'd5, 64'd5,
           mk(5'd4, 64'd0, 64'd5, 4'b1100, 3'b001, 9'd0, 1'b1, 1'b0));
      step("addi", 1'b0, enc_i(12'hFFF, 5'd1, 3'b000, 5'd6, 7'b0010011), 64'd10, 64'd123,
           mk(5'd6, 64'd9, 64'd123, 4'b1100, 3'b001, 9'h1FF, 1'b1, 1'b0));
      sw_instr = enc_s(12'd8, 5'd7, 5'd1, 3'b010, 7'b0100011);
      step("sw", 1'b0, sw_instr, 64'h1000, 64'hDEAD,
           mk(5'd7, 64'h1008, 64'hDEAD, 4'b1101, 3'b000, 9'd8, 1'b0, 1'b0));
      step("bne", 1'b0, enc_s(12'd40, 5'd3, 5'd1, 3'b001, 7'b1100011), 64'd9, 64'd9,
           mk(5'd3, 64'd0, 64'd9, 4'b0100, 3'b000, 9'd40, 1'b1, 1'b0));
      step("blt", 1'b0, enc_s(12'h1F0, 5'd5, 5'd1, 3'b100, 7'b1100011), 64'd3, 64'd5,
           mk(5'd5, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5, 4'b1000, 3'b000, 9'h1F0, 1'b0, 1'b0));
      step("beq_ovf", 1'b0, enc_s(12'd0, 5'd2, 5'd1, 3'b000, 7'b1100011),
           64'h8000_0000_0000_0000, 64'd1,
           mk(5'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'b0000, 3'b000, 9'd0, 1'b1, 1'b1));
      step("fifo", 1'b0, enc_i(12'd11, 5'd1, 3'b001, 5'd9, 7'b0001011), 64'd2, 64'd3,
           mk(5'd11, 64'd5, 64'd3, 4'b1100, 3'b111, 9'd0, 1'b0, 1'b0));
      step("load", 1'b0, enc_i(12'h010, 5'd1, 3'b011, 5'd8, 7'b0000011), 64'h100, 64'd5,
           mk(5'd16, 64'h110, 64'd5, 4'b1100, 3'b011, 9'h010, 1'b0, 1'b0));
      step("jal", 1'b0, enc_i(12'd100, 5'd0, 3'b000, 5'd1, 7'b1101111), 64'd1, 64'd1,
           mk(5'd4, 64'd2, 64'd1, 4'b1110, 3'b000, 9'd100, 1'b0, 1'b0));
      step("srai", 1'b0, enc_i(12'h404, 5'd1, 3'b101, 5'd12, 7'b0010011),
           64'h8000_0000_0000_0000, 64'd77,
           mk(5'd12, sra_exp, 64'd77, 4'b1100, 3'b001, 9'h004, 1'b0, 1'b0));
      step("srli", 1'b0, enc_i(12'h004, 5'd1, 3'b101, 5'd12, 7'b0010011),
           64'h8000_0000_0000_0000, 64'd77,
           mk(5'd12, srl_exp, 64'd77, 4'b1100, 3'b001, 9'h004, 1'b0, 1'b0));
      step("sll", 1'b0, enc_r(1'b0, 5'd2, 5'd1, 3'b001, 5'd13), 64'd1, 64'd67,
           mk(5'd13, sll_exp, 64'd67, 4'b1100, 3'b001, 9'd0, 1'b0, 1'b0));
      step("xor", 1'b0, enc_r(1'b0, 5'd2, 5'd1, 3'b100, 5'd1), 64'hF0F0, 64'hFF00,
           mk(5'd1, 64'h0FF0, 64'hFF00, 4'b1100, 3'b001, 9'd0, 1'b0, 1'b0));
      step("or", 1'b0, enc_r(1'b0, 5'd2, 5'd1, 3'b110, 5'd1), 64'hF0F0, 64'hFF00,
           mk(5'd1, 64'hFFF0, 64'hFF00, 4'b1100, 3'b001, 9'd0, 1'b0, 1'b0));
      step("and", 1'b0, enc_r(1'b0, 5'd2, 5'd1, 3'b111, 5'd1), 64'hF0F0, 64'hFF00,
           mk(5'd1, 64'hF000, 64'hFF00, 4'b1100, 3'b001, 9'd0, 1'b0, 1'b0));
      step("slt", 1'b0, enc_r(1'b0, 5'd2, 5'd1, 3'b010, 5'd2), 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
           mk(5'd2, 64'd1, 64'd1, 4'b1100, 3'b001, 9'd0, 1'b0, 1'b0));
      step("sltu", 1'b0, enc_r(1'b0, 5'd2, 5'd1, 3'b011, 5'd2), 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
           mk(5'd2, 64'd0, 64'd1, 4'b1100, 3'b001, 9'd0, 1'b0, 1'b0));
      step("badop", 1'b0, enc_r(1'b1, 5'd2, 5'd1, 3'b001, 5'd7), 64'd3, 64'd4,
           mk(5'd7, 64'd0, 64'd4, 4'b1100, 3'b001, 9'd0, 1'b0, 1'b0));
      step("bubble", 1'b0, 32'h0000_007F, 64'd1, 64'd2,
           mk(5'd0, 64'd3, 64'd2, 4'b1100, 3'b000, 9'd0, 1'b0, 1'b0));
      step("rst_sw", 1'b1, sw_instr, 64'h1000, 64'hDEAD,
           mk(5'd0, 64'd0, 64'd0, 4'b1100, 3'b000, 9'd0, 1'b0, 1'b0));
      step("post_rst", 1'b0, enc_r(1'b0, 5'd2, 5'd1, 3'b000, 5'd10), 64'd1, 64'd2,
           mk(5'd10, 64'd3, 64'd2, 4'b1100, 3'b001, 9'd0, 1'b0, 1'b0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
